// File: rtl/mat_op_seq.sv
// Matrix operation sequencer: validates dimensions, then walks operands element by
// element through the store read ports and writes each result element in row-major order.
module mat_op_seq #(
    parameter int DATA_W  = 8,
    parameter int MAX_DIM = 5,
    parameter int DIM_W   = 3,
    parameter int ADDR_W  = 5,
    parameter int ACC_W   = 19
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_op,
    input  logic [2:0]        op_sel,
    input  logic [DIM_W-1:0]  a_rows,
    input  logic [DIM_W-1:0]  a_cols,
    input  logic [DIM_W-1:0]  b_rows,
    input  logic [DIM_W-1:0]  b_cols,
    input  logic [DATA_W-1:0] scalar,
    input  logic [DATA_W-1:0] a_rdata,
    input  logic [DATA_W-1:0] b_rdata,
    output logic              rd_en,
    output logic [ADDR_W-1:0] a_addr,
    output logic [ADDR_W-1:0] b_addr,
    output logic              r_we,
    output logic [ADDR_W-1:0] r_addr,
    output logic [ACC_W-1:0]  r_wdata,
    output logic [DIM_W-1:0]  r_rows,
    output logic [DIM_W-1:0]  r_cols,
    output logic              busy,
    output logic              done,
    output logic              error_flag
);

    typedef enum logic [2:0] {
        S_IDLE, S_CHECK, S_READ, S_ACC, S_WRITE, S_DONE, S_ERR
    } state_t;

    localparam logic [2:0]       OP_ADD    = 3'd0;
    localparam logic [2:0]       OP_SCALE  = 3'd1;
    localparam logic [2:0]       OP_TRANS  = 3'd2;
    localparam logic [2:0]       OP_MMUL   = 3'd3;
    localparam logic [DIM_W-1:0] MAX_DIM_C = DIM_W'(MAX_DIM);
    localparam logic [DIM_W-1:0] ONE       = DIM_W'(1);

    state_t              state_q, state_d;
    logic [2:0]          op_q, op_d;
    logic [DIM_W-1:0]    ar_q, ar_d, ac_q, ac_d, br_q, br_d, bc_q, bc_d;
    logic [DATA_W-1:0]   scalar_q, scalar_d;
    logic [DIM_W-1:0]    i_q, i_d, j_q, j_d, k_q, k_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic                rd_en_q, r_we_q, done_q, err_q;
    logic [ADDR_W-1:0]   a_addr_q, a_addr_d, b_addr_q, b_addr_d, r_addr_q, r_addr_d;
    logic [ACC_W-1:0]    r_wdata_q, r_wdata_d;
    logic [DIM_W-1:0]    r_rows_q, r_rows_d, r_cols_q, r_cols_d;
    logic [DIM_W-1:0]    rows_c, cols_c;
    logic                bad, last;

    function automatic logic dim_bad(input logic [DIM_W-1:0] d);
        return (d == '0) || (d > MAX_DIM_C);
    endfunction

    // Row-major linear address: row * stride + col.
    function automatic logic [ADDR_W-1:0] lin(input logic [DIM_W-1:0] row,
                                              input logic [DIM_W-1:0] stride,
                                              input logic [DIM_W-1:0] col);
        return ADDR_W'(row) * ADDR_W'(stride) + ADDR_W'(col);
    endfunction

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        ar_d      = ar_q;
        ac_d      = ac_q;
        br_d      = br_q;
        bc_d      = bc_q;
        scalar_d  = scalar_q;
        i_d       = i_q;
        j_d       = j_q;
        k_d       = k_q;
        acc_d     = acc_q;
        a_addr_d  = a_addr_q;
        b_addr_d  = b_addr_q;
        r_addr_d  = r_addr_q;
        r_wdata_d = r_wdata_q;
        r_rows_d  = r_rows_q;
        r_cols_d  = r_cols_q;
        rows_c    = ar_q;
        cols_c    = ac_q;
        bad       = 1'b0;
        last      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_op) begin
                    op_d     = op_sel;
                    ar_d     = a_rows;
                    ac_d     = a_cols;
                    br_d     = b_rows;
                    bc_d     = b_cols;
                    scalar_d = scalar;
                    state_d  = S_CHECK;
                end
            end
            S_CHECK: begin
                bad = dim_bad(ar_q) || dim_bad(ac_q);
                case (op_q)
                    OP_ADD:   bad = bad || (ar_q != br_q) || (ac_q != bc_q);
                    OP_SCALE: ;
                    OP_TRANS: begin
                        rows_c = ac_q;
                        cols_c = ar_q;
                    end
                    OP_MMUL: begin
                        bad    = bad || dim_bad(br_q) || dim_bad(bc_q) || (ac_q != br_q);
                        cols_c = bc_q;
                    end
                    default:  bad = 1'b1;
                endcase
                if (bad) begin
                    state_d = S_ERR;
                end else begin
                    r_rows_d = rows_c;
                    r_cols_d = cols_c;
                    i_d      = '0;
                    j_d      = '0;
                    k_d      = '0;
                    acc_d    = '0;
                    state_d  = S_READ;
                end
            end
            S_READ: state_d = S_ACC;
            S_ACC: begin
                state_d = S_WRITE;
                case (op_q)
                    OP_ADD:   acc_d = ACC_W'(a_rdata) + ACC_W'(b_rdata);
                    OP_SCALE: acc_d = ACC_W'(a_rdata) * ACC_W'(scalar_q);
                    OP_TRANS: acc_d = ACC_W'(a_rdata);
                    default: begin
                        acc_d = acc_q + ACC_W'(a_rdata) * ACC_W'(b_rdata);
                        if (k_q < ac_q - ONE) begin
                            k_d     = k_q + ONE;
                            state_d = S_READ;
                        end
                    end
                endcase
            end
            S_WRITE: begin
                acc_d = '0;
                k_d   = '0;
                last  = (i_q == r_rows_q - ONE) && (j_q == r_cols_q - ONE);
                if (j_q < r_cols_q - ONE) begin
                    j_d = j_q + ONE;
                end else begin
                    j_d = '0;
                    i_d = i_q + ONE;
                end
                state_d = last ? S_DONE : S_READ;
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Addresses are prepared one cycle ahead so they are registered alongside rd_en.
        if (state_d == S_READ) begin
            case (op_q)
                OP_TRANS: a_addr_d = lin(j_d, ac_q, i_d);
                OP_MMUL: begin
                    a_addr_d = lin(i_d, ac_q, k_d);
                    b_addr_d = lin(k_d, bc_q, j_d);
                end
                default: begin
                    a_addr_d = lin(i_d, ac_q, j_d);
                    b_addr_d = lin(i_d, ac_q, j_d);
                end
            endcase
        end
        if (state_d == S_WRITE) begin
            r_addr_d  = lin(i_q, r_cols_q, j_q);
            r_wdata_d = acc_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            op_q      <= '0;
            ar_q      <= '0;
            ac_q      <= '0;
            br_q      <= '0;
            bc_q      <= '0;
            scalar_q  <= '0;
            i_q       <= '0;
            j_q       <= '0;
            k_q       <= '0;
            acc_q     <= '0;
            rd_en_q   <= 1'b0;
            r_we_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            a_addr_q  <= '0;
            b_addr_q  <= '0;
            r_addr_q  <= '0;
            r_wdata_q <= '0;
            r_rows_q  <= '0;
            r_cols_q  <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            ar_q      <= ar_d;
            ac_q      <= ac_d;
            br_q      <= br_d;
            bc_q      <= bc_d;
            scalar_q  <= scalar_d;
            i_q       <= i_d;
            j_q       <= j_d;
            k_q       <= k_d;
            acc_q     <= acc_d;
            rd_en_q   <= (state_d == S_READ);
            r_we_q    <= (state_d == S_WRITE);
            done_q    <= (state_d == S_DONE);
            err_q     <= (state_d == S_ERR);
            a_addr_q  <= a_addr_d;
            b_addr_q  <= b_addr_d;
            r_addr_q  <= r_addr_d;
            r_wdata_q <= r_wdata_d;
            r_rows_q  <= r_rows_d;
            r_cols_q  <= r_cols_d;
        end
    end

    assign rd_en      = rd_en_q;
    assign a_addr     = a_addr_q;
    assign b_addr     = b_addr_q;
    assign r_we       = r_we_q;
    assign r_addr     = r_addr_q;
    assign r_wdata    = r_wdata_q;
    assign r_rows     = r_rows_q;
    assign r_cols     = r_cols_q;
    assign busy       = (state_q == S_CHECK) || (state_q == S_READ) ||
                        (state_q == S_ACC)   || (state_q == S_WRITE);
    assign done       = done_q;
    assign error_flag = err_q;

endmodule

// File: tb/tb_mat_op_seq.sv
// Bench for mat_op_seq: directed and random operations checked against a
// matrix-level reference model through an expected-write queue.
module tb_mat_op_seq;
  localparam int DATA_W = 8;
  localparam int DIM_W  = 3;
  localparam int ADDR_W = 5;
  localparam int ACC_W  = 19;
  localparam int LIMIT  = 400;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start_op = 1'b0;
  logic [2:0]        op_sel = '0;
  logic [DIM_W-1:0]  a_rows = '0, a_cols = '0, b_rows = '0, b_cols = '0;
  logic [DATA_W-1:0] scalar = '0;
  logic [DATA_W-1:0] a_rdata = '0, b_rdata = '0;
  logic              rd_en, r_we, busy, done, error_flag;
  logic [ADDR_W-1:0] a_addr, b_addr, r_addr;
  logic [ACC_W-1:0]  r_wdata;
  logic [DIM_W-1:0]  r_rows, r_cols;

  logic [DATA_W-1:0] a_mem [32];
  logic [DATA_W-1:0] b_mem [32];
  logic [ADDR_W+ACC_W-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  mat_op_seq dut (
    .clk(clk), .rst_n(rst_n), .start_op(start_op), .op_sel(op_sel),
    .a_rows(a_rows), .a_cols(a_cols), .b_rows(b_rows), .b_cols(b_cols),
    .scalar(scalar), .a_rdata(a_rdata), .b_rdata(b_rdata),
    .rd_en(rd_en), .a_addr(a_addr), .b_addr(b_addr),
    .r_we(r_we), .r_addr(r_addr), .r_wdata(r_wdata),
    .r_rows(r_rows), .r_cols(r_cols),
    .busy(busy), .done(done), .error_flag(error_flag)
  );

  // operand store: registered read, data valid the cycle after rd_en
  always @(posedge clk) begin
    if (rd_en) begin
      a_rdata <= a_mem[a_addr];
      b_rdata <= b_mem[b_addr];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [ADDR_W+ACC_W-1:0] e;
    if (r_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("write_addr", 32'(r_addr), 32'(e[ACC_W +: ADDR_W]));
        chk("write_data", 32'(r_wdata), 32'(e[ACC_W-1:0]));
      end
    end
  end

  // ---------------- reference model ----------------
  task automatic model_op(input int op, input int ar, input int ac, input int br, input int bc,
                          input int sc, output bit ok, output int rr, output int rc,
                          output int exp_cyc);
    bit a_ok, b_ok;
    int v;
    a_ok = (ar >= 1) && (ar <= 5) && (ac >= 1) && (ac <= 5);
    b_ok = (br >= 1) && (br <= 5) && (bc >= 1) && (bc <= 5);
    case (op)
      0:       ok = a_ok && (ar == br) && (ac == bc);
      1, 2:    ok = a_ok;
      3:       ok = a_ok && b_ok && (ac == br);
      default: ok = 1'b0;
    endcase
    rr = 0;
    rc = 0;
    exp_cyc = 2;
    if (!ok) return;
    rr = (op == 2) ? ac : ar;
    rc = (op == 2) ? ar : ((op == 3) ? bc : ac);
    for (int r = 0; r < rr; r++) begin
      for (int c = 0; c < rc; c++) begin
        case (op)
          0: v = int'(a_mem[r*ac+c]) + int'(b_mem[r*ac+c]);
          1: v = int'(a_mem[r*ac+c]) * sc;
          2: v = int'(a_mem[c*ac+r]);
          default: begin
            v = 0;
            for (int k = 0; k < ac; k++) v += int'(a_mem[r*ac+k]) * int'(b_mem[k*bc+c]);
          end
        endcase
        exp_q.push_back({ADDR_W'(r*rc+c), ACC_W'(v)});
      end
    end
    exp_cyc = 2 + rr * rc * ((op == 3) ? 2*ac + 1 : 3);
  endtask

  // ---------------- driver ----------------
  task automatic run_op(input string tag, input int op, input int ar, input int ac,
                        input int br, input int bc, input int sc, input bit disturb);
    bit ok, seen_done, seen_err;
    int rr, rc, exp_cyc, cyc, busy_cnt;
    model_op(op, ar, ac, br, bc, sc, ok, rr, rc, exp_cyc);
    @(negedge clk);
    start_op = 1'b1;
    op_sel   = 3'(op);
    a_rows   = DIM_W'(ar);
    a_cols   = DIM_W'(ac);
    b_rows   = DIM_W'(br);
    b_cols   = DIM_W'(bc);
    scalar   = DATA_W'(sc);
    @(posedge clk);
    cyc = 0;
    busy_cnt = 0;
    seen_done = 1'b0;
    seen_err = 1'b0;
    while (!(seen_done || seen_err) && cyc < LIMIT) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        start_op = 1'b0;
        a_rows = DIM_W'($urandom_range(0, 7));
        a_cols = DIM_W'($urandom_range(0, 7));
        scalar = DATA_W'($urandom_range(0, 255));
      end
      if (disturb && cyc == 3) begin
        start_op = 1'b1;
        op_sel = 3'($urandom_range(0, 7));
      end
      if (disturb && cyc == 4) start_op = 1'b0;
      if (busy) busy_cnt++;
      if (done) seen_done = 1'b1;
      if (error_flag) seen_err = 1'b1;
    end
    start_op = 1'b0;
    chk({tag, "_finished"}, 32'(seen_done || seen_err), 32'd1);
    chk({tag, "_done"}, 32'(seen_done), 32'(ok));
    chk({tag, "_error"}, 32'(seen_err), 32'(!ok));
    chk({tag, "_end_cycle"}, 32'(cyc), 32'(exp_cyc));
    chk({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(exp_cyc - 1));
    if (ok) begin
      chk({tag, "_r_rows"}, 32'(r_rows), 32'(rr));
      chk({tag, "_r_cols"}, 32'(r_cols), 32'(rc));
    end
    chk({tag, "_pending_writes"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  task automatic clear_mems();
    for (int i = 0; i < 32; i++) begin
      a_mem[i] = '0;
      b_mem[i] = '0;
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_ctrl"}, 32'({rd_en, r_we, done, error_flag, busy}), 32'd0);
    chk({tag, "_dims"}, 32'({r_rows, r_cols}), 32'd0);
    chk({tag, "_addrs"}, 32'({a_addr, b_addr, r_addr}), 32'd0);
    chk({tag, "_wdata"}, 32'(r_wdata), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int cyc, we_cnt, op, ar, ac, br, bc;
    clear_mems();
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;

    // add 2x2
    a_mem[0] = 1;  a_mem[1] = 2;  a_mem[2] = 3;  a_mem[3] = 4;
    b_mem[0] = 10; b_mem[1] = 20; b_mem[2] = 30; b_mem[3] = 40;
    run_op("add2x2", 0, 2, 2, 2, 2, 0, 1'b0);
    // scalar 1x3
    clear_mems();
    a_mem[0] = 255; a_mem[1] = 2; a_mem[2] = 0;
    run_op("scalar1x3", 1, 1, 3, 0, 0, 255, 1'b0);
    // transpose 2x3
    for (int i = 0; i < 6; i++) a_mem[i] = DATA_W'(i + 1);
    run_op("trans2x3", 2, 2, 3, 0, 0, 0, 1'b0);
    // matmul 2x2
    clear_mems();
    a_mem[0] = 1; a_mem[1] = 2; a_mem[2] = 3; a_mem[3] = 4;
    b_mem[0] = 5; b_mem[1] = 6; b_mem[2] = 7; b_mem[3] = 8;
    run_op("mmul2x2", 3, 2, 2, 2, 2, 0, 1'b0);
    // matmul 5x5 full scale, with an ignored launch mid-run
    for (int i = 0; i < 32; i++) begin
      a_mem[i] = 8'd255;
      b_mem[i] = 8'd255;
    end
    run_op("mmul5x5", 3, 5, 5, 5, 5, 0, 1'b1);
    // rejected operations
    run_op("err_add_dims", 0, 2, 2, 2, 3, 0, 1'b0);
    run_op("err_mmul_inner", 3, 2, 3, 2, 3, 0, 1'b0);
    run_op("err_op7", 7, 2, 2, 2, 2, 0, 1'b0);
    run_op("err_rows0", 1, 0, 2, 0, 0, 3, 1'b0);
    run_op("err_rows6", 2, 6, 2, 0, 0, 0, 1'b0);

    // reset in cycle 8 of a matmul
    @(negedge clk);
    start_op = 1'b1;
    op_sel = 3'd3;
    a_rows = 3'd5; a_cols = 3'd5; b_rows = 3'd5; b_cols = 3'd5;
    @(posedge clk);
    cyc = 0;
    while (cyc < 8) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) start_op = 1'b0;
    end
    chk("mid_op_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    we_cnt = 0;
    repeat (30) begin
      @(negedge clk);
      if (r_we) we_cnt++;
    end
    chk("writes_after_reset", 32'(we_cnt), 32'd0);
    run_op("after_reset", 0, 2, 2, 2, 2, 0, 1'b0);

    // random operations
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < 32; i++) begin
        a_mem[i] = DATA_W'($urandom_range(0, 255));
        b_mem[i] = DATA_W'($urandom_range(0, 255));
      end
      op = $urandom_range(0, 4);
      if (op == 4) op = $urandom_range(4, 7);
      ar = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 1) * 6 : $urandom_range(1, 5);
      ac = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 1) * 6 : $urandom_range(1, 5);
      br = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 6) : ((op == 0) ? ar : ac);
      bc = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 6) :
           ((op == 0) ? ac : $urandom_range(1, 5));
      run_op("random", op, ar, ac, br, bc, $urandom_range(0, 255), $urandom_range(0, 2) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
